instr_encoder: RTL and testbench

- Inverse of the main control decoder: takes an instruction class plus operand fields and assembles the 32-bit MIPS word whose opcode the decoder consumes.
- Buffers assembled words in a small FIFO and streams them to the instruction-memory write port at sequential word addresses.
- Used to load programs into instruction memory before the CPU is released from reset, and by test benches to generate instruction streams.

---
 rtl/instr_encoder.sv | 127 ++++++++++++
 tb/tb_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: assembles 32-bit MIPS instruction words from a class tag plus
// operand fields, buffers them in a small FIFO, and streams them to an
// instruction-memory write port at consecutive word addresses.
//
// Outputs are driven only from registered state (FIFO storage, pointers,
// occupancy, address/count registers). No combinational path exists from
// in_* to out_*. in_ready depends only on the registered occupancy.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_BEQ = 3'd1;
  localparam logic [2:0] KIND_LW  = 3'd2;
  localparam logic [2:0] KIND_SW  = 3'd3;
  localparam logic [2:0] KIND_J   = 3'd4;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   occ;

  logic        full;
  logic        empty;
  logic        kind_ok;
  logic        accept;
  logic        push;
  logic        pop;
  logic        flush;
  logic [31:0] enc_word;

  assign full     = (occ == (PW+1)'(DEPTH));
  assign empty    = (occ == '0);
  assign in_ready = !full;
  assign out_valid = !empty;

  // Reset and clr are the same operation; both override any handshake that cycle.
  assign flush   = reset || clr;
  assign kind_ok = (in_kind <= KIND_J);
  assign accept  = in_valid && !full;
  // Invalid kinds still complete the handshake but never reach the FIFO.
  assign push    = accept && kind_ok;
  assign pop     = out_valid && out_ready;

  // Empty FIFO reads as zero so the word bus has a defined value at reset.
  assign im_wdata = empty ? 32'h0 : mem[rptr];

  // Field packing per instruction class; unused fields of a class are dropped.
  always_comb begin
    enc_word = 32'h0;
    unique case (in_kind)
      KIND_R:   enc_word = {OP_R, in_rs, in_rt, in_rd, in_shamt, in_funct};
      KIND_BEQ: enc_word = {OP_BEQ, in_rs, in_rt, in_imm};
      KIND_LW:  enc_word = {OP_LW, in_rs, in_rt, in_imm};
      KIND_SW:  enc_word = {OP_SW, in_rs, in_rt, in_imm};
      KIND_J:   enc_word = {OP_J, in_target};
      default:  enc_word = 32'h0;
    endcase
  end

  // FIFO storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wptr] <= enc_word;
    end
  end

  // Pointers, occupancy, output address/count and sticky error.
  always_ff @(posedge clk) begin
    if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      im_addr  <= BASE_ADDR;
      word_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr     <= rptr + PW'(1);
        im_addr  <= im_addr + ADDR_W'(4);
        word_cnt <= word_cnt + ADDR_W'(1);
      end
      if (push && !pop) begin
        occ <= occ + (PW+1)'(1);
      end else if (pop && !push) begin
        occ <= occ - (PW+1)'(1);
      end
      if (accept && !kind_ok) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for encoding, plus hand-written
// sequences for backpressure, stall, invalid kind, clr/reset and address wrap.
module tb_instr_encoder;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_ready = 1'b0;
  logic        out_ready2 = 1'b0;

  logic        in_ready, out_valid, err;
  logic [31:0] im_addr, im_wdata, word_cnt;
  logic        in_ready2, out_valid2, err2;
  logic [3:0]  im_addr2, word_cnt2;
  logic [31:0] im_wdata2;

  int checks = 0;
  int errors = 0;

  vec_t vecs [9];

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .im_addr(im_addr), .im_wdata(im_wdata), .word_cnt(word_cnt), .err(err)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .im_addr(im_addr2), .im_wdata(im_wdata2), .word_cnt(word_cnt2), .err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_kind   = v.kind;
    in_rs     = v.rs;
    in_rt     = v.rt;
    in_rd     = v.rd;
    in_shamt  = v.shamt;
    in_funct  = v.funct;
    in_imm    = v.imm;
    in_target = v.target;
  endtask

  task automatic drive_lw(input logic [4:0] rt, input logic [15:0] imm);
    in_kind = 3'd2;
    in_rs   = 5'd0;
    in_rt   = rt;
    in_imm  = imm;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  function automatic logic [31:0] lw_word(input logic [4:0] rt, input logic [15:0] imm);
    return {6'b100011, 5'd0, rt, imm};
  endfunction

  initial begin
    //          kind  rs     rt     rd     shamt  funct   imm        target         word
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20,  16'h0000,  26'h0,         32'h00221820};
    vecs[1] = '{3'd2, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00,  16'h0004,  26'h0,         32'h8C080004};
    vecs[2] = '{3'd3, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00,  16'h0008,  26'h0,         32'hAC080008};
    vecs[3] = '{3'd1, 5'd1,  5'd2,  5'd0,  5'd0,  6'h00,  16'hFFFF,  26'h0,         32'h1022FFFF};
    vecs[4] = '{3'd4, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00,  16'h0000,  26'h0000010,   32'h08000010};
    vecs[5] = '{3'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F,  16'h0000,  26'h0,         32'h03FFFFFF};
    vecs[6] = '{3'd4, 5'd5,  5'd9,  5'd7,  5'd3,  6'h11,  16'hABCD,  26'h3FFFFFF,   32'h0BFFFFFF};
    vecs[7] = '{3'd2, 5'd3,  5'd4,  5'd7,  5'd9,  6'h3F,  16'h1234,  26'h155,       32'h8C641234};
    vecs[8] = '{3'd1, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00,  16'h0000,  26'h3FFFFFF,   32'h10000000};

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_im_addr", im_addr, 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_word_cnt", word_cnt, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_im_addr2", 32'(im_addr2), 32'd8);
    reset = 1'b0;

    // Encoding table: push one word, check it at the head, pop it.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("enc_out_valid", 32'(out_valid), 32'd1);
      chk("enc_word", im_wdata, vecs[i].word);
      chk("enc_addr", im_addr, 32'(4 * i));
      chk("enc_cnt", word_cnt, 32'(i));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("enc_drained", 32'(out_valid), 32'd0);
    end
    chk("enc_final_cnt", word_cnt, 32'd9);
    chk("enc_final_addr", im_addr, 32'd36);

    // Backpressure: five requests into a four-entry FIFO.
    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_lw(5'(i + 1), 16'h0100 + 16'(i));
      in_valid = 1'b1;
      chk("bp_ready_open", 32'(in_ready), 32'd1);
      tick();
    end
    drive_lw(5'd5, 16'h0104);
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_ready_full2", 32'(in_ready), 32'd0);
    chk("bp_head0", im_wdata, lw_word(5'd1, 16'h0100));
    out_ready = 1'b1;
    tick();
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    chk("bp_head1", im_wdata, lw_word(5'd2, 16'h0101));
    chk("bp_addr1", im_addr, 32'd4);
    tick();
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_word", im_wdata, lw_word(5'(i + 1), 16'h0100 + 16'(i)));
      chk("bp_addr", im_addr, 32'(4 * i));
      tick();
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_cnt", word_cnt, 32'd5);
    out_ready = 1'b0;

    // Stall stability with one word buffered.
    do_clr();
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_word", im_wdata, 32'h00221820);
      chk("stall_addr", im_addr, 32'd0);
      chk("stall_cnt", word_cnt, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_cnt_after", word_cnt, 32'd1);

    // Invalid kind between two lw requests.
    do_clr();
    drive_lw(5'd1, 16'h0001);
    in_valid = 1'b1;
    tick();
    chk("inv_err_before", 32'(err), 32'd0);
    in_kind = 3'd6;
    chk("inv_ready", 32'(in_ready), 32'd1);
    tick();
    chk("inv_err_set", 32'(err), 32'd1);
    drive_lw(5'd2, 16'h0002);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("inv_word0", im_wdata, 32'h8C010001);
    chk("inv_addr0", im_addr, 32'd0);
    tick();
    chk("inv_word1", im_wdata, 32'h8C020002);
    chk("inv_addr1", im_addr, 32'd4);
    tick();
    out_ready = 1'b0;
    chk("inv_empty", 32'(out_valid), 32'd0);
    chk("inv_cnt", word_cnt, 32'd2);
    chk("inv_err_sticky", 32'(err), 32'd1);

    // clr mid-stream with three words buffered; same-cycle request dropped.
    for (int i = 1; i < 4; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    chk("clr_pre_addr", im_addr, 32'd8);
    drive(vecs[4]);
    in_valid = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_cnt", word_cnt, 32'd0);
    chk("clr_addr", im_addr, 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    tick();
    chk("clr_dropped", 32'(out_valid), 32'd0);
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("clr_next_addr", im_addr, 32'd0);
    chk("clr_next_word", im_wdata, 32'h00221820);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("clr_next_cnt", word_cnt, 32'd1);

    // Reset mid-stream takes priority over clr and a same-cycle push.
    drive(vecs[2]);
    in_valid = 1'b1;
    tick();
    reset = 1'b1;
    clr = 1'b1;
    tick();
    reset = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_cnt", word_cnt, 32'd0);
    chk("rst_mid_addr", im_addr, 32'd0);

    // Address wrap on the 4-bit instance starting at 8.
    for (int i = 1; i < 4; i++) begin
      drive(vecs[i]);
      in_valid2 = 1'b1;
      tick();
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    chk("wrap_addr0", 32'(im_addr2), 32'd8);
    chk("wrap_word0", im_wdata2, 32'h8C080004);
    tick();
    chk("wrap_addr1", 32'(im_addr2), 32'd12);
    chk("wrap_word1", im_wdata2, 32'hAC080008);
    tick();
    chk("wrap_addr2", 32'(im_addr2), 32'd0);
    chk("wrap_word2", im_wdata2, 32'h1022FFFF);
    tick();
    out_ready2 = 1'b0;
    chk("wrap_empty", 32'(out_valid2), 32'd0);
    chk("wrap_cnt", 32'(word_cnt2), 32'd3);
    chk("wrap_addr_end", 32'(im_addr2), 32'd4);
    chk("wrap_main_idle", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
